// File: rtl/ahb_arb_pkg.sv
// Shared AHB transfer/response encodings and arbiter state type.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [0:0] {ARB_M0, ARB_M1} arb_state_e;

endpackage

// File: rtl/ahb_arb_if.sv
// Bus bundle between the two AHB masters, the arbiter and the AHB2APB bridge.
interface ahb_arb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [1:0]        Hbusreq;
  logic [1:0]        Htrans_m0;
  logic [1:0]        Htrans_m1;
  logic [ADDR_W-1:0] Haddr_m0;
  logic [ADDR_W-1:0] Haddr_m1;
  logic              Hwrite_m0;
  logic              Hwrite_m1;
  logic [DATA_W-1:0] Hwdata_m0;
  logic [DATA_W-1:0] Hwdata_m1;
  logic              Hreadyout;
  logic [1:0]        Hresp;

  logic [1:0]        Hgrant;
  logic              Hmaster;
  logic [1:0]        Htrans;
  logic [ADDR_W-1:0] Haddr;
  logic              Hwrite;
  logic [DATA_W-1:0] Hwdata;
  logic              Hreadyin;
  logic              Hready_m;
  logic [1:0]        Hresp_m;

  // Arbiter side.
  modport slave (
    input  Hbusreq, Htrans_m0, Htrans_m1, Haddr_m0, Haddr_m1, Hwrite_m0, Hwrite_m1,
           Hwdata_m0, Hwdata_m1, Hreadyout, Hresp,
    output Hgrant, Hmaster, Htrans, Haddr, Hwrite, Hwdata, Hreadyin, Hready_m, Hresp_m
  );

  // Masters plus bridge side.
  modport master (
    output Hbusreq, Htrans_m0, Htrans_m1, Haddr_m0, Haddr_m1, Hwrite_m0, Hwrite_m1,
           Hwdata_m0, Hwdata_m1, Hreadyout, Hresp,
    input  Hgrant, Hmaster, Htrans, Haddr, Hwrite, Hwdata, Hreadyin, Hready_m, Hresp_m
  );

endinterface

// File: rtl/ahb_arb_rr.sv
// Two-way round-robin picker: returns the next address-phase owner at a release point.
module ahb_arb_rr (
  input  logic [1:0] Hbusreq,
  input  logic       rr_last,
  input  logic       owner,
  output logic       next_owner
);

  logic other;

  always_comb begin
    other      = ~owner;
    next_owner = owner;
    if (Hbusreq[other] && Hbusreq[owner]) begin
      next_owner = ~rr_last;
    end else if (Hbusreq[other]) begin
      next_owner = other;
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Two-master AHB-lite arbiter in front of the AHB2APB bridge; round-robin, burst-safe.
// Define AHB_ARB_MAX_HOLD_EN to cap an owner's tenure at MAX_HOLD accepted beats.
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic      Hclk,
  input logic      Hreset,
  ahb_arb_if.slave bus
);

  arb_state_e state_q, state_d;
  logic       data_owner_q, data_owner_d;
  logic       rr_last_q, rr_last_d;

  logic              owner, other, other_req, own_req;
  logic [1:0]        own_trans;
  logic [ADDR_W-1:0] own_addr;
  logic              own_write;
  logic [DATA_W-1:0] data_mux;
  logic              burst_lock, release_pt, force_pt, picked, new_owner, handover;

  assign owner     = (state_q == ARB_M1);
  assign other     = ~owner;
  assign own_req   = bus.Hbusreq[owner];
  assign other_req = bus.Hbusreq[other];
  assign own_trans = owner ? bus.Htrans_m1 : bus.Htrans_m0;
  assign own_addr  = owner ? bus.Haddr_m1  : bus.Haddr_m0;
  assign own_write = owner ? bus.Hwrite_m1 : bus.Hwrite_m0;
  assign data_mux  = data_owner_q ? bus.Hwdata_m1 : bus.Hwdata_m0;

  assign burst_lock = (own_trans == HTRANS_SEQ) || (own_trans == HTRANS_BUSY);
  assign release_pt = bus.Hreadyout &&
                      ((own_trans == HTRANS_IDLE) || (!own_req && !burst_lock));

  ahb_arb_rr u_rr (
    .Hbusreq    (bus.Hbusreq),
    .rr_last    (rr_last_q),
    .owner      (owner),
    .next_owner (picked)
  );

`ifdef AHB_ARB_MAX_HOLD_EN
  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;

  // A NONSEQ accepted at the forcing edge still completes; only SEQ/BUSY are protected.
  assign force_pt = bus.Hreadyout && other_req && (hold_cnt_q >= CntW'(MAX_HOLD)) &&
                    ((own_trans == HTRANS_NONSEQ) || (own_trans == HTRANS_IDLE));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (handover) begin
      hold_cnt_d = '0;
    end else if (bus.Hreadyout &&
                 ((own_trans == HTRANS_NONSEQ) || (own_trans == HTRANS_SEQ)) &&
                 (hold_cnt_q < CntW'(MAX_HOLD))) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign force_pt = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    data_owner_d = bus.Hreadyout ? owner : data_owner_q;
    new_owner    = owner;
    if (force_pt) begin
      new_owner = other;
    end else if (release_pt) begin
      new_owner = picked;
    end
    handover = (new_owner != owner);
    // An accepted NONSEQ uses up the owner's turn for the next tie-break.
    if (bus.Hreadyout && (own_trans == HTRANS_NONSEQ)) begin
      rr_last_d = owner;
    end
    if (handover) begin
      state_d   = new_owner ? ARB_M1 : ARB_M0;
      rr_last_d = new_owner;
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q      <= ARB_M0;
      data_owner_q <= 1'b0;
      rr_last_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_owner_q <= data_owner_d;
      rr_last_q    <= rr_last_d;
    end
  end

  always_comb begin
    bus.Hgrant   = owner ? 2'b10 : 2'b01;
    bus.Hmaster  = owner;
    bus.Htrans   = Hreset ? HTRANS_IDLE : own_trans;
    bus.Haddr    = Hreset ? '0 : own_addr;
    bus.Hwrite   = Hreset ? 1'b0 : own_write;
    bus.Hwdata   = Hreset ? '0 : data_mux;
    bus.Hreadyin = bus.Hreadyout;
    bus.Hready_m = bus.Hreadyout;
    bus.Hresp_m  = bus.Hresp;
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: reset, single write, contention, burst lock, waits, hold.
module tb_ahb_arbiter;
  import ahb_arb_pkg::*;

  logic Hclk;
  logic Hreset;
  int   total = 0;
  int   bad   = 0;

  ahb_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [1:0] exp);
    check_eq(tag, {30'd0, bus.Hgrant}, {30'd0, exp});
    check_eq({tag, "_master"}, {31'd0, bus.Hmaster}, {31'd0, exp[1]});
  endtask

  task automatic do_reset();
    Hreset = 1'b1;
    tick();
    tick();
    Hreset = 1'b0;
  endtask

  initial begin
    Hreset        = 1'b1;
    bus.Hbusreq   = 2'b10;
    bus.Htrans_m0 = HTRANS_NONSEQ;
    bus.Htrans_m1 = HTRANS_NONSEQ;
    bus.Haddr_m0  = 32'h1111_0000;
    bus.Haddr_m1  = 32'h2222_0000;
    bus.Hwrite_m0 = 1'b1;
    bus.Hwrite_m1 = 1'b1;
    bus.Hwdata_m0 = 32'h0000_aaaa;
    bus.Hwdata_m1 = 32'h0000_bbbb;
    bus.Hreadyout = 1'b1;
    bus.Hresp     = HRESP_OKAY;

    // Reset held for two edges with both masters driving NONSEQ.
    tick();
    tick();
    settle();
    check_grant("rst_grant", 2'b01);
    check_eq("rst_htrans", {30'd0, bus.Htrans}, 32'd0);
    check_eq("rst_haddr", bus.Haddr, 32'd0);
    check_eq("rst_hwdata", bus.Hwdata, 32'd0);
    check_eq("rst_hwrite", {31'd0, bus.Hwrite}, 32'd0);

    // Single write from M0.
    Hreset        = 1'b0;
    bus.Hbusreq   = 2'b01;
    bus.Htrans_m0 = HTRANS_IDLE;
    bus.Htrans_m1 = HTRANS_IDLE;
    tick();
    bus.Htrans_m0 = HTRANS_NONSEQ;
    bus.Haddr_m0  = 32'h8000_0000;
    bus.Hwrite_m0 = 1'b1;
    settle();
    check_eq("wr_htrans", {30'd0, bus.Htrans}, {30'd0, HTRANS_NONSEQ});
    check_eq("wr_haddr", bus.Haddr, 32'h8000_0000);
    check_eq("wr_hwrite", {31'd0, bus.Hwrite}, 32'd1);
    tick();
    bus.Htrans_m0 = HTRANS_IDLE;
    bus.Hwdata_m0 = 32'h1234_5678;
    bus.Hwdata_m1 = 32'hdead_beef;
    settle();
    check_eq("wr_hwdata", bus.Hwdata, 32'h1234_5678);
    check_grant("wr_grant", 2'b01);
    tick();

    // Contention: both request, M0 writes then goes IDLE.
    do_reset();
    bus.Hbusreq   = 2'b11;
    bus.Htrans_m0 = HTRANS_NONSEQ;
    bus.Haddr_m0  = 32'h8000_0000;
    bus.Htrans_m1 = HTRANS_NONSEQ;
    bus.Haddr_m1  = 32'h8000_0004;
    bus.Hwrite_m1 = 1'b1;
    settle();
    check_grant("ct_grant0", 2'b01);
    check_eq("ct_haddr0", bus.Haddr, 32'h8000_0000);
    tick();
    bus.Htrans_m0 = HTRANS_IDLE;
    bus.Hwdata_m0 = 32'h1111_2222;
    settle();
    check_grant("ct_grant1", 2'b01);
    check_eq("ct_hwdata0", bus.Hwdata, 32'h1111_2222);
    tick();
    settle();
    check_grant("ct_handover", 2'b10);
    check_eq("ct_haddr1", bus.Haddr, 32'h8000_0004);
    check_eq("ct_htrans1", {30'd0, bus.Htrans}, {30'd0, HTRANS_NONSEQ});
    check_eq("ct_hwrite1", {31'd0, bus.Hwrite}, 32'd1);
    tick();

    // Wait states during M1's data phase.
    bus.Htrans_m1 = HTRANS_IDLE;
    bus.Hwdata_m1 = 32'hcafe_f00d;
    bus.Hwdata_m0 = 32'h3333_4444;
    bus.Hreadyout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_grant("ws_grant", 2'b10);
      check_eq("ws_hwdata", bus.Hwdata, 32'hcafe_f00d);
      check_eq("ws_hreadyin", {31'd0, bus.Hreadyin}, 32'd0);
      tick();
    end
    bus.Hreadyout = 1'b1;
    settle();
    check_eq("ws_hwdata_end", bus.Hwdata, 32'hcafe_f00d);
    check_grant("ws_grant_end", 2'b10);
    tick();

    // Burst lock: M0 NONSEQ + 3 SEQ, drops its request mid-burst, M1 requests throughout.
    bus.Htrans_m0 = HTRANS_NONSEQ;
    bus.Haddr_m0  = 32'h8000_0000;
    bus.Hwdata_m1 = 32'hffff_ffff;
    settle();
    check_grant("bl_grant0", 2'b01);
    check_eq("bl_haddr0", bus.Haddr, 32'h8000_0000);
    tick();
    for (int k = 1; k <= 3; k++) begin
      bus.Hbusreq   = 2'b10;
      bus.Htrans_m0 = HTRANS_SEQ;
      bus.Haddr_m0  = 32'h8000_0000 + 32'(4 * k);
      bus.Hwdata_m0 = 32'h0000_00b0 + 32'(k - 1);
      settle();
      check_grant("bl_grant_seq", 2'b01);
      check_eq("bl_haddr_seq", bus.Haddr, 32'h8000_0000 + 32'(4 * k));
      check_eq("bl_hwdata_seq", bus.Hwdata, 32'h0000_00b0 + 32'(k - 1));
      tick();
    end
    bus.Htrans_m0 = HTRANS_IDLE;
    bus.Hwdata_m0 = 32'h0000_00b3;
    settle();
    check_grant("bl_grant_idle", 2'b01);
    check_eq("bl_hwdata_last", bus.Hwdata, 32'h0000_00b3);
    tick();
    settle();
    check_grant("bl_handover", 2'b10);

    // Error response passes through and does not move the grant.
    bus.Hresp = HRESP_ERROR;
    settle();
    check_eq("err_hresp_m", {30'd0, bus.Hresp_m}, {30'd0, HRESP_ERROR});
    check_eq("err_hready_m", {31'd0, bus.Hready_m}, 32'd1);
    tick();
    bus.Hresp = HRESP_OKAY;
    settle();
    check_grant("err_grant", 2'b10);

    // Reset while M1 owns the bus.
    do_reset();
    settle();
    check_grant("rst2_grant", 2'b01);

    // Back-to-back NONSEQ from M0 while M1 requests.
    bus.Hbusreq   = 2'b11;
    bus.Htrans_m1 = HTRANS_IDLE;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] exp_g;
      bus.Htrans_m0 = HTRANS_NONSEQ;
      bus.Haddr_m0  = 32'h9000_0000 + 32'(4 * i);
`ifdef AHB_ARB_MAX_HOLD_EN
      exp_g = (i < 5) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      settle();
      check_grant("hold_grant", exp_g);
      check_eq("hold_onehot", $countones(bus.Hgrant), 32'd1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Two-master AHB-lite arbiter placed in front of Bridge_Top, so the AHB2APB bridge can be shared between a CPU-side master (M0) and a DMA-side master (M1).
- Grants bus ownership with round-robin arbitration and never breaks a burst.
- Muxes the address/control signals by the address-phase owner and Hwdata by the data-phase owner.
- Broadcasts the bridge's Hreadyout and Hresp back to both masters.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, write data width.
- MAX_HOLD, 4, maximum accepted beats per tenure (used only with AHB_ARB_MAX_HOLD_EN).

Ports:
- Hclk  in  1  bus clock, rising edge.
- Hreset  in  1  synchronous, active-high reset.
- Hbusreq  in  2  bus request; bit i belongs to master i.
- Htrans_m0, Htrans_m1  in  2 each  master transfer type.
- Haddr_m0, Haddr_m1  in  ADDR_W each  master address.
- Hwrite_m0, Hwrite_m1  in  1 each  master write flag.
- Hwdata_m0, Hwdata_m1  in  DATA_W each  master write data.
- Hreadyout  in  1  ready from the bridge.
- Hresp  in  2  response from the bridge.
- Hgrant  out  2  one-hot grant to the masters.
- Hmaster  out  1  index of the address-phase owner.
- Htrans  out  2  to the bridge.
- Haddr  out  ADDR_W  to the bridge.
- Hwrite  out  1  to the bridge.
- Hwdata  out  DATA_W  to the bridge.
- Hreadyin  out  1  to the bridge; equals Hreadyout.
- Hready_m  out  1  Hreadyout broadcast to both masters.
- Hresp_m  out  2  Hresp broadcast to both masters.

Behaviour:
- Reset (synchronous, Hreset=1 at a rising edge):
  - Hgrant=2'b01, Hmaster=0, data_owner=0, rr_last=1 (M0 wins the first tie), state=ARB_M0.
  - While Hreset=1, Htrans is forced to IDLE (2'b00); Haddr, Hwdata and Hwrite output zero.
- States:
  - ARB_M0: M0 owns the address phase.
  - ARB_M1: M1 owns the address phase.
  - No separate park state: with no requests, the current owner stays granted (parked).
- Address mux:
  - Htrans, Haddr and Hwrite are taken combinationally from master[Hmaster].
  - A non-owner's signals never reach the bridge.
- Data owner:
  - data_owner <= Hmaster at every edge with Hreadyout=1.
  - Hwdata = Hwdata_m[data_owner].
  - While Hreadyout=0, data_owner holds.
- Release point: an edge where Hreadyout=1 and either:
  - owner Htrans==IDLE, or
  - owner Hbusreq==0 and owner Htrans!=SEQ/BUSY.
- Handover (at a release point):
  - If the other master requests, then at that same edge Hgrant becomes the other master's one-hot, Hmaster switches, state switches, and rr_last <= new owner.
  - If the other master does not request, nothing changes.
- Handover latency:
  - The new owner's address phase is visible to the bridge in the cycle immediately after the switching edge. No dead cycle.
  - A granted master must drive a valid Htrans (IDLE or NONSEQ) from the first cycle Hgrant is high.
- Burst lock: while owner Htrans is SEQ or BUSY, no handover occurs regardless of requests.
- Simultaneous requests at a release point from an idle owner: the master != rr_last wins.
- Wait states: while Hreadyout=0, Hgrant, Hmaster, data_owner and state all hold.
- Error response: Hresp is passed through unchanged; ERROR does not affect arbitration.
- Reset mid-transfer: all registers return to their reset values at the next edge. The outstanding bridge transfer is abandoned, and masters must also be in reset.
- Hgrant is always exactly one-hot; Hmaster always equals the index of the set Hgrant bit.

Optional Feature:
- Macro: AHB_ARB_MAX_HOLD_EN.
- Defined:
  - A tenure counter counts accepted NONSEQ/SEQ beats of the owner (Hreadyout=1). It clears on handover and on reset.
  - When count>=MAX_HOLD and the other master requests, an edge where Hreadyout=1 and owner Htrans is NONSEQ or IDLE also forces a handover. The owner's NONSEQ accepted at that edge still completes.
  - The forced handover never occurs on SEQ/BUSY.
- Not defined: no counter exists; an owner keeps the grant until the normal release point.

Decomposition:
- Package ahb_arb_pkg contains:
  - HTRANS_IDLE=2'b00, HTRANS_BUSY=2'b01, HTRANS_NONSEQ=2'b10, HTRANS_SEQ=2'b11;
  - HRESP_OKAY=2'b00, HRESP_ERROR=2'b01;
  - the state typedef {ARB_M0, ARB_M1}.
- One sub-module is natural: ahb_arb_rr. It takes Hbusreq, rr_last and the owner and returns the next owner (combinational picker).
- The FSM, counter and muxes stay in ahb_arbiter.

Test Plan:
1. Reset:
   - Stimulus: assert Hreset for 2 cycles, with M1 driving NONSEQ.
   - Required: Hgrant=01, Hmaster=0, Htrans=IDLE, Haddr=0.
2. Single write from M0:
   - Stimulus: Hbusreq=01; M0 drives NONSEQ, Haddr=0x8000_0000, Hwrite=1, Hwdata=0x1234_5678 in the next cycle.
   - Required: the bridge sees that address and Htrans, then that Hwdata one cycle later; Hgrant stays 01.
3. Contention:
   - Stimulus: Hbusreq=11 after reset; M0 performs one single write, then drives IDLE.
   - Required: Hgrant=01 throughout M0's write; at the IDLE edge Hgrant->10, Hmaster->1; M1's NONSEQ at 0x8000_0004 reaches the bridge the next cycle.
4. Burst lock:
   - Stimulus: M0 drives NONSEQ followed by 3 SEQ beats (0x8000_0000..0x8000_000C) while M1 requests throughout.
   - Required: no handover before M0's IDLE; Hwdata is sourced from M0 for all 4 data phases.
5. Wait states:
   - Stimulus: the bridge holds Hreadyout=0 for 3 cycles during the data phase of M1's write.
   - Required: Hgrant, Hmaster and data_owner remain constant; Hwdata holds M1's value.
6. AHB_ARB_MAX_HOLD_EN with MAX_HOLD=4:
   - Stimulus: M0 issues back-to-back single NONSEQ transfers while M1 requests.
   - Required: handover to M1 occurs at the edge accepting M0's 5th beat or later, never on SEQ; without the macro, M0 keeps the grant indefinitely.
